// File: rtl/leading_zero_counter_pkg.sv
// Shared constants and helpers for the leading/trailing zero counter.
// The registered outputs reset to "empty, count zero", so a pipelined
// consumer sees no valid index until the first real vector is clocked in.
package leading_zero_counter_pkg;

    localparam logic RST_EMPTY = 1'b1;

    // Number of tree leaves: the input is padded up to a power of two.
    function automatic int lzc_leaves(input int cnt_width);
        return 1 << cnt_width;
    endfunction

endpackage

// File: rtl/leading_zero_counter_lzc_node.sv
// Two-input merge cell of the zero-count tree.
// Each child reports whether its subtree holds a set bit and the offset of
// the first set bit inside that subtree. The left child covers the lower
// indices, so it wins whenever it is valid. Otherwise the right child's
// offset is shifted past the left half by setting bit LEVEL-1.
// Index buses are carried at full result width. Bits at or above LEVEL-1
// are always zero in the children, so OR-ing in the select bit is
// equivalent to prepending it.
module lzc_node #(
    parameter int IDX_W = 1,
    parameter int LEVEL = 1
) (
    input  logic             valid_l,
    input  logic [IDX_W-1:0] idx_l,
    input  logic             valid_r,
    input  logic [IDX_W-1:0] idx_r,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] SEL_BIT = IDX_W'(1) << (LEVEL - 1);

    // Merge the two children: any set bit makes the node valid, and the
    // lower-index child takes priority.
    always_comb begin
        valid = valid_l | valid_r;
        if (valid_l) begin
            idx = idx_l;
        end else begin
            idx = idx_r | SEL_BIT;
        end
    end

endmodule

// File: rtl/leading_zero_counter.sv
// Leading/trailing zero counter with combinational and registered outputs.
// MODE=0 reports the index of the lowest set bit. MODE=1 bit-reverses the
// input and reuses the same tree, which yields the distance of the highest
// set bit from the MSB. The tree is padded with zero leaves up to a power
// of two, so padding can never win and never clears the empty flag.
// The count is forced to zero when the input is empty; consumers qualify
// the count with the empty flag.
module leading_zero_counter
    import leading_zero_counter_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter bit MODE      = 1'b0,
    parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] cnt_q_o,
    output logic                 empty_q_o
);

    localparam int LEAVES = lzc_leaves(CNT_WIDTH);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "leading_zero_counter: WIDTH must be at least 1");
    end

    // Heap-ordered tree: node 1 is the root, node n has children 2n and
    // 2n+1, and leaves occupy nodes LEAVES .. 2*LEAVES-1.
    logic                 valid_t [1:2*LEAVES-1];
    logic [CNT_WIDTH-1:0] idx_t   [1:2*LEAVES-1];

    // Leaf layer: optional bit reversal, zero padding beyond WIDTH.
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < WIDTH) begin : g_real
            if (MODE) begin : g_rev
                assign valid_t[LEAVES+i] = in_i[WIDTH-1-i];
            end else begin : g_fwd
                assign valid_t[LEAVES+i] = in_i[i];
            end
        end else begin : g_pad
            assign valid_t[LEAVES+i] = 1'b0;
        end
        assign idx_t[LEAVES+i] = '0;
    end

    // Merge layers, from the root (depth 0) down to the nodes just above
    // the leaves (depth CNT_WIDTH-1).
    for (genvar d = 0; d < CNT_WIDTH; d++) begin : g_depth
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int N = (1 << d) + j;
            lzc_node #(
                .IDX_W (CNT_WIDTH),
                .LEVEL (CNT_WIDTH - d)
            ) u_node (
                .valid_l (valid_t[2*N]),
                .idx_l   (idx_t[2*N]),
                .valid_r (valid_t[2*N+1]),
                .idx_r   (idx_t[2*N+1]),
                .valid   (valid_t[N]),
                .idx     (idx_t[N])
            );
        end
    end

    // Root result: empty when nothing is set, count masked to zero then.
    always_comb begin
        empty_o = ~valid_t[1];
        cnt_o   = valid_t[1] ? idx_t[1] : '0;
    end

    // Registered copies for pipelined consumers; reset wins over new data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q_o   <= '0;
            empty_q_o <= RST_EMPTY;
        end else begin
            cnt_q_o   <= cnt_o;
            empty_q_o <= empty_o;
        end
    end

endmodule

// File: tb/tb_leading_zero_counter.sv
// Self-checking bench for leading_zero_counter.
// Fourteen instances cover WIDTH in {1,2,3,5,8,17,64} with both modes.
// Expected counts come from a plain scan loop over the input bits.
module tb_leading_zero_counter;

    localparam int NW = 7;

    function automatic int width_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 5;
            4: return 8;
            5: return 17;
            default: return 64;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_v      [NW][2];
    logic [6:0]  cnt_v     [NW][2];
    logic        empty_v   [NW][2];
    logic [6:0]  cnt_q_v   [NW][2];
    logic        empty_q_v [NW][2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NW; g++) begin : g_w
        for (genvar m = 0; m < 2; m++) begin : g_m
            localparam int W  = width_of(g);
            localparam int CW = (W > 1) ? $clog2(W) : 1;
            logic [CW-1:0] cnt_w;
            logic [CW-1:0] cnt_q_w;
            logic          empty_w;
            logic          empty_q_w;
            leading_zero_counter #(
                .WIDTH (W),
                .MODE  (m != 0)
            ) dut (
                .clk_i     (clk),
                .rst_i     (rst),
                .in_i      (in_v[g][m][W-1:0]),
                .cnt_o     (cnt_w),
                .empty_o   (empty_w),
                .cnt_q_o   (cnt_q_w),
                .empty_q_o (empty_q_w)
            );
            assign cnt_v[g][m]     = 7'(cnt_w);
            assign cnt_q_v[g][m]   = 7'(cnt_q_w);
            assign empty_v[g][m]   = empty_w;
            assign empty_q_v[g][m] = empty_q_w;
        end
    end

    // Reference: scan from the LSB for trailing zeros, from the MSB for
    // leading zeros; the first set bit found fixes the count.
    function automatic void ref_model(input logic [63:0] v, input int w, input int mode,
                                      output int cnt, output bit empty);
        cnt   = 0;
        empty = 1'b1;
        if (mode == 0) begin
            for (int i = 0; i < w; i++) begin
                if (empty && v[i]) begin
                    cnt   = i;
                    empty = 1'b0;
                end
            end
        end else begin
            for (int j = w - 1; j >= 0; j--) begin
                if (empty && v[j]) begin
                    cnt   = w - 1 - j;
                    empty = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [63:0] rand_vec(input int w);
        logic [63:0] v;
        logic [63:0] mask;
        int          kind;
        v    = {$urandom(), $urandom()};
        kind = $urandom_range(0, 15);
        if (kind < 5) begin
            v = v & {$urandom(), $urandom()} & {$urandom(), $urandom()};
        end else if (kind < 11) begin
            v = 64'd1 << $urandom_range(0, w - 1);
        end else if (kind == 11) begin
            v = '0;
        end
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        return v & mask;
    endfunction

    task automatic clear_inputs();
        for (int g = 0; g < NW; g++) begin
            in_v[g][0] = '0;
            in_v[g][1] = '0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        in_v[4][0] = 64'h10;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cnt_q_v[4][0] !== 7'd0 || empty_q_v[4][0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hold: cnt_q=%0d empty_q=%0b, expected 0/1", cnt_q_v[4][0], empty_q_v[4][0]);
        end
        checks++;
        if (cnt_v[4][0] !== 7'd4 || empty_v[4][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL comb_during_reset: cnt=%0d empty=%0b, expected 4/0", cnt_v[4][0], empty_v[4][0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt_q_v[4][0] !== 7'd4 || empty_q_v[4][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: cnt_q=%0d empty_q=%0b, expected 4/0", cnt_q_v[4][0], empty_q_v[4][0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_q_v[4][0] !== 7'd0 || empty_q_v[4][0] !== 1'b1 || cnt_v[4][0] !== 7'd4) begin
            errors++;
            $display("[TB] FAIL reset_reassert: cnt_q=%0d empty_q=%0b cnt=%0d, expected 0/1/4",
                     cnt_q_v[4][0], empty_q_v[4][0], cnt_v[4][0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt_q_v[4][0] !== 7'd4 || empty_q_v[4][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rerelease: cnt_q=%0d empty_q=%0b, expected 4/0", cnt_q_v[4][0], empty_q_v[4][0]);
        end
    endtask

    typedef struct {
        int          g;
        int          m;
        logic [63:0] v;
        int          cnt;
        bit          empty;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[$];
        tbl.push_back('{4, 0, 64'h28, 3, 1'b0});
        tbl.push_back('{4, 1, 64'h28, 2, 1'b0});
        tbl.push_back('{4, 0, 64'h00, 0, 1'b1});
        tbl.push_back('{4, 1, 64'h00, 0, 1'b1});
        tbl.push_back('{4, 0, 64'h80, 7, 1'b0});
        tbl.push_back('{4, 0, 64'h01, 0, 1'b0});
        tbl.push_back('{4, 0, 64'hFF, 0, 1'b0});
        tbl.push_back('{4, 1, 64'h01, 7, 1'b0});
        tbl.push_back('{4, 1, 64'h80, 0, 1'b0});
        tbl.push_back('{4, 1, 64'hFF, 0, 1'b0});
        tbl.push_back('{3, 0, 64'h10, 4, 1'b0});
        tbl.push_back('{3, 0, 64'h14, 2, 1'b0});
        tbl.push_back('{3, 1, 64'h01, 4, 1'b0});
        tbl.push_back('{3, 1, 64'h00, 0, 1'b1});
        tbl.push_back('{3, 1, 64'h14, 0, 1'b0});
        tbl.push_back('{0, 0, 64'h1, 0, 1'b0});
        tbl.push_back('{0, 0, 64'h0, 0, 1'b1});
        tbl.push_back('{0, 1, 64'h1, 0, 1'b0});
        tbl.push_back('{0, 1, 64'h0, 0, 1'b1});
        tbl.push_back('{2, 0, 64'h4, 2, 1'b0});
        tbl.push_back('{2, 1, 64'h1, 2, 1'b0});
        tbl.push_back('{5, 0, 64'h10000, 16, 1'b0});
        tbl.push_back('{5, 1, 64'h1, 16, 1'b0});
        tbl.push_back('{6, 0, 64'h8000_0000_0000_0000, 63, 1'b0});
        tbl.push_back('{6, 1, 64'h1, 63, 1'b0});
        foreach (tbl[k]) begin
            clear_inputs();
            in_v[tbl[k].g][tbl[k].m] = tbl[k].v;
            #1;
            checks++;
            if (cnt_v[tbl[k].g][tbl[k].m] !== 7'(tbl[k].cnt) || empty_v[tbl[k].g][tbl[k].m] !== tbl[k].empty) begin
                errors++;
                $display("[TB] FAIL directed_%0d (W=%0d M=%0d in=%h): cnt=%0d empty=%0b, expected %0d/%0b",
                         k, width_of(tbl[k].g), tbl[k].m, tbl[k].v,
                         cnt_v[tbl[k].g][tbl[k].m], empty_v[tbl[k].g][tbl[k].m], tbl[k].cnt, tbl[k].empty);
            end
        end
    endtask

    task automatic test_random();
        int exp_cnt;
        bit exp_empty;
        for (int n = 0; n < 1000; n++) begin
            for (int g = 0; g < NW; g++) begin
                in_v[g][0] = rand_vec(width_of(g));
                in_v[g][1] = rand_vec(width_of(g));
            end
            #1;
            for (int g = 0; g < NW; g++) begin
                for (int m = 0; m < 2; m++) begin
                    ref_model(in_v[g][m], width_of(g), m, exp_cnt, exp_empty);
                    checks++;
                    if (cnt_v[g][m] !== 7'(exp_cnt) || empty_v[g][m] !== exp_empty) begin
                        errors++;
                        $display("[TB] FAIL random (W=%0d M=%0d in=%h): cnt=%0d empty=%0b, expected %0d/%0b",
                                 width_of(g), m, in_v[g][m], cnt_v[g][m], empty_v[g][m], exp_cnt, exp_empty);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_cnt   [NW][2];
        bit exp_empty [NW][2];
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 60; n++) begin
            for (int g = 0; g < NW; g++) begin
                for (int m = 0; m < 2; m++) begin
                    in_v[g][m] = rand_vec(width_of(g));
                    ref_model(in_v[g][m], width_of(g), m, exp_cnt[g][m], exp_empty[g][m]);
                end
            end
            @(negedge clk);
            for (int g = 0; g < NW; g++) begin
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (cnt_q_v[g][m] !== 7'(exp_cnt[g][m]) || empty_q_v[g][m] !== exp_empty[g][m]) begin
                        errors++;
                        $display("[TB] FAIL registered (W=%0d M=%0d in=%h): cnt_q=%0d empty_q=%0b, expected %0d/%0b",
                                 width_of(g), m, in_v[g][m], cnt_q_v[g][m], empty_q_v[g][m],
                                 exp_cnt[g][m], exp_empty[g][m]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_with_change();
        @(negedge clk);
        rst = 1'b0;
        in_v[4][1] = 64'h01;
        @(negedge clk);
        rst = 1'b1;
        in_v[4][1] = 64'h20;
        @(negedge clk);
        checks++;
        if (cnt_q_v[4][1] !== 7'd0 || empty_q_v[4][1] !== 1'b1 || cnt_v[4][1] !== 7'd2) begin
            errors++;
            $display("[TB] FAIL reset_vs_change: cnt_q=%0d empty_q=%0b cnt=%0d, expected 0/1/2",
                     cnt_q_v[4][1], empty_q_v[4][1], cnt_v[4][1]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt_q_v[4][1] !== 7'd2 || empty_q_v[4][1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_change: cnt_q=%0d empty_q=%0b, expected 2/0",
                     cnt_q_v[4][1], empty_q_v[4][1]);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_with_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
